mudi_iter: RTL and testbench
============================

# mudi_iter

Parametrised HI/LO multiply/divide unit for the E stage of the pipelined MIPS core. It is the successor to the fixed-latency unit:
- operand width is a parameter;
- multiply latency is a parameter;
- division is a true iterative restoring divider (one quotient bit per cycle) instead of a one-shot divide with a dummy counter;
- multiply-accumulate can be compiled in.

The unit keeps HI/LO commit/rollback semantics so that an exception in M cancels the instruction that issued in the previous cycle.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width (≥ 4, even)
- MUL_LAT, 5, cycles from start to HI/LO commit for multiply ops (≥ 1)

Ports (one clock; reset is asynchronous and active-low):
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- A  in  WIDTH  operand rs
- B  in  WIDTH  operand rt
- MuDiOp  in  4  0 mult, 1 multu, 2 div, 3 divu, 4 mfhi, 5 mflo, 6 mthi, 7 mtlo, 8 madd, 9 maddu, 10 msub, 11 msubu
- start  in  1  launch arithmetic op (0–3, 8–11)
- We  in  1  write HI/LO (ops 6, 7)
- Din  in  WIDTH  mthi/mtlo data
- exp_in  in  1  M-stage exception; cancels the op accepted on the previous edge
- buzy  out  1  op in flight
- Dout  out  WIDTH  mfhi → HI, mflo → LO, else 0

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset (async, Reset=0): state IDLE; HI, LO, shadows, counters cleared; buzy=0; Dout follows MuDiOp against HI/LO=0.
- IDLE + start + mult-class op:
  - product computed at full 2·WIDTH width, signed or unsigned per op;
  - counter=MUL_LAT → MUL.
- MUL:
  - counter decrements; commit when it reaches 0, then IDLE.
  - mult/multu: {HI,LO}=product.
  - madd*/msub*: {HI,LO}={HI,LO}±product, using HI/LO at commit time, modulo 2^(2·WIDTH).
- IDLE + start + div/divu:
  - B==0: op ignored, no state change, HI/LO unchanged, buzy stays 0.
  - Otherwise: latch operand magnitudes (signed: absolute values; result signs recorded) → DIV with counter=WIDTH.
- DIV:
  - one restoring step per cycle: shift remainder, trial-subtract divisor, set quotient bit;
  - counter reaches 0 → FIX.
- FIX:
  - apply signs: quotient truncates toward zero, remainder takes dividend sign;
  - commit LO=quotient, HI=remainder → IDLE.
  - Signed overflow (−2^(WIDTH−1) / −1): LO=−2^(WIDTH−1), HI=0.
- IDLE + We + !start, op 6/7:
  - save {HI,LO} into shadow, then write HI or LO from Din;
  - sets mt_prev flag for one cycle.
- start/We with a non-matching op, or asserted while buzy: ignored. Issue stage must stall on buzy.
- mfhi/mflo: combinational from committed HI/LO; in-flight results are not visible before commit.
- exp_in=1 on an edge:
  - mt_prev set: restore HI/LO from shadow.
  - Else if an arithmetic op was accepted on the previous edge: abort to IDLE with no commit.
  - Otherwise: no effect.
  - New start/We on the same edge is ignored.
- Priority per edge: Reset > exp_in > commit/step > start > We.

## Timing
- Start sampled at edge T0; buzy=1 from just after T0.
- Multiply: HI/LO commit at edge T0+MUL_LAT; buzy falls at that edge.
- Divide: DIV for WIDTH edges, FIX commits at edge T0+WIDTH+1; buzy falls there (33 cycles for WIDTH=32).
- mthi/mtlo visible on Dout the cycle after the We edge.
- Back-to-back: a new start is accepted on the same edge buzy falls, or later.
- exp_in is only honoured on the edge immediately after acceptance (T0+1). For MUL_LAT=1 that edge is also the commit edge; exp_in wins and nothing commits.
- Reset asserted mid-operation: immediate abort, all registers cleared, no commit.

## Configuration
- MUDI_MACC_EN defined: ops 8–11 implemented as above.
- Undefined: ops 8–11 are treated as unknown, start is ignored, and accumulate logic is not synthesised.

## Test plan
- Reset low mid-div → buzy=0 immediately, HI=LO=0, Dout=0 on mfhi.
- WIDTH=32: div A=−7, B=2 → buzy high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=0xFFFFFFFF, B=0x10 → LO=0x0FFFFFFF, HI=0xF.
- mult A=0x80000000, B=0x80000000 (MUL_LAT=5) → commit after 5 cycles, HI=0x40000000, LO=0. multu same operands → HI=0x40000000, LO=0.
- div by 0 with HI=0x12 → buzy stays 0, HI stays 0x12. div 0x80000000 / −1 → LO=0x80000000, HI=0.
- mthi Din=0xAB, then exp_in=1 next edge → HI restored to prior value. mult start, then exp_in next edge → buzy=0, HI/LO unchanged.
- MUDI_MACC_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → HI=1, LO=0. msub A=1, B=1 from HI=LO=0 → HI=LO=0xFFFFFFFF.

Source files
------------

// File: rtl/mudi_iter.sv
// HI/LO multiply/divide unit: multiply with MUL_LAT-cycle commit and an iterative restoring divider.
// Define MUDI_MACC_EN to build the madd/maddu/msub/msubu accumulate ops.
module mudi_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       MuDiOp,
  input  logic             start,
  input  logic             We,
  input  logic [WIDTH-1:0] Din,
  input  logic             exp_in,
  output logic             buzy,
  output logic [WIDTH-1:0] Dout
);

  // state  | meaning
  // S_IDLE | accepting start / mthi / mtlo
  // S_MUL  | product held, counting down to the HI/LO commit
  // S_DIV  | one restoring quotient bit per cycle
  // S_FIX  | sign correction and HI/LO commit
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam int CMAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, shi_q, shi_d, slo_q, slo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               negq_q, negq_d, negr_q, negr_d;
  logic               mt_prev_q, mt_prev_d, acc_prev_q, acc_prev_d;
`ifdef MUDI_MACC_EN
  logic               mac_q, mac_d, msub_q, msub_d;
`endif

  logic               op_mul, op_div, op_sgn, fin;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_c, mul_res;
  logic [WIDTH-1:0]   a_mag, b_mag, q_fin, r_fin, rem_try;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;

  always_comb begin
    op_sgn = (MuDiOp == 4'd0) || (MuDiOp == 4'd2) || (MuDiOp == 4'd8) || (MuDiOp == 4'd10);
    op_div = (MuDiOp == 4'd2) || (MuDiOp == 4'd3);
`ifdef MUDI_MACC_EN
    op_mul = (MuDiOp <= 4'd1) || ((MuDiOp >= 4'd8) && (MuDiOp <= 4'd11));
`else
    op_mul = (MuDiOp <= 4'd1);
`endif
  end

  // sign-extending to 2*WIDTH makes one unsigned multiply serve both signednesses
  assign a_ext  = {{WIDTH{op_sgn & A[WIDTH-1]}}, A};
  assign b_ext  = {{WIDTH{op_sgn & B[WIDTH-1]}}, B};
  assign prod_c = a_ext * b_ext;

  assign a_mag   = (op_sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag   = (op_sgn && B[WIDTH-1]) ? -B : B;
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, dvs_q};
  assign rem_try = rem_sh[WIDTH-1:0] - dvs_q;
  assign q_fin   = negq_q ? -quo_q : quo_q;
  assign r_fin   = negr_q ? -rem_q : rem_q;
  assign fin     = ((state_q == S_MUL) && (cnt_q == CW'(1))) || (state_q == S_FIX);

`ifdef MUDI_MACC_EN
  always_comb begin
    if (msub_q)     mul_res = {hi_q, lo_q} - prod_q;
    else if (mac_q) mul_res = {hi_q, lo_q} + prod_q;
    else            mul_res = prod_q;
  end
`else
  assign mul_res = prod_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    shi_d      = shi_q;
    slo_d      = slo_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    mt_prev_d  = 1'b0;
    acc_prev_d = 1'b0;
`ifdef MUDI_MACC_EN
    mac_d      = mac_q;
    msub_d     = msub_q;
`endif
    if (exp_in && mt_prev_q) begin
      hi_d = shi_q;
      lo_d = slo_q;
    end else if (exp_in && acc_prev_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_MUL: begin
          if (cnt_q == CW'(1)) begin
            {hi_d, lo_d} = mul_res;
            state_d      = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          rem_d = rem_ge ? rem_try : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
        S_FIX: begin
          lo_d    = q_fin;
          hi_d    = r_fin;
          state_d = S_IDLE;
        end
        default: ;
      endcase
      // a new start may launch on the same edge the previous op commits
      if (!exp_in && ((state_q == S_IDLE) || fin)) begin
        if (start && op_mul) begin
          prod_d     = prod_c;
          cnt_d      = CW'(MUL_LAT);
          state_d    = S_MUL;
          acc_prev_d = 1'b1;
`ifdef MUDI_MACC_EN
          mac_d      = (MuDiOp >= 4'd8);
          msub_d     = (MuDiOp >= 4'd10);
`endif
        end else if (start && op_div && (B != '0)) begin
          rem_d      = '0;
          quo_d      = a_mag;
          dvs_d      = b_mag;
          negq_d     = op_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          negr_d     = op_sgn & A[WIDTH-1];
          cnt_d      = CW'(WIDTH);
          state_d    = S_DIV;
          acc_prev_d = 1'b1;
        end else if ((state_q == S_IDLE) && We && !start &&
                     ((MuDiOp == 4'd6) || (MuDiOp == 4'd7))) begin
          shi_d     = hi_q;
          slo_d     = lo_q;
          mt_prev_d = 1'b1;
          if (MuDiOp == 4'd6) hi_d = Din;
          else                lo_d = Din;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      shi_q      <= '0;
      slo_q      <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      mt_prev_q  <= 1'b0;
      acc_prev_q <= 1'b0;
`ifdef MUDI_MACC_EN
      mac_q      <= 1'b0;
      msub_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      shi_q      <= shi_d;
      slo_q      <= slo_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      mt_prev_q  <= mt_prev_d;
      acc_prev_q <= acc_prev_d;
`ifdef MUDI_MACC_EN
      mac_q      <= mac_d;
      msub_q     <= msub_d;
`endif
    end
  end

  assign buzy = (state_q != S_IDLE);

  always_comb begin
    Dout = '0;
    if (MuDiOp == 4'd4)      Dout = hi_q;
    else if (MuDiOp == 4'd5) Dout = lo_q;
  end

endmodule

// File: tb/tb_mudi_iter.sv
// Bench for mudi_iter (WIDTH=32, MUL_LAT=5): directed literal cases plus random traffic
// compared every cycle against a cycle-count/arithmetic model of the HI/LO unit.
module tb_mudi_iter;
  localparam int W  = 32;
  localparam int ML = 5;
`ifdef MUDI_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [W-1:0]  A = '0, B = '0, Din = '0;
  logic [3:0]    MuDiOp = 4'd0;
  logic          start = 1'b0, We = 1'b0, exp_in = 1'b0;
  logic          buzy;
  logic [W-1:0]  Dout;

  always #5 Clk = ~Clk;

  mudi_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .MuDiOp(MuDiOp), .start(start),
    .We(We), .Din(Din), .exp_in(exp_in), .buzy(buzy), .Dout(Dout)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // reference model: pending result plus edges left until it lands in HI/LO
  logic [31:0] m_hi, m_lo, m_shi, m_slo;
  logic [63:0] m_res;
  int          m_left, m_kind;
  bit          m_mt, m_acc, was_idle, fin, ex_mt, ex_acc, is_mulc;
  longint      sa, sb;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_hi = 0; m_lo = 0; m_shi = 0; m_slo = 0; m_res = 0;
      m_left = 0; m_kind = 0; m_mt = 0; m_acc = 0;
    end else begin
      was_idle = (m_left == 0);
      fin      = 1'b0;
      ex_mt    = exp_in && m_mt;
      ex_acc   = exp_in && !m_mt && m_acc;
      m_mt     = 1'b0;
      m_acc    = 1'b0;
      is_mulc  = (MuDiOp <= 1) || (MACC && MuDiOp >= 8 && MuDiOp <= 11);
      if (ex_mt) begin
        m_hi = m_shi;
        m_lo = m_slo;
      end else if (ex_acc) begin
        m_left = 0;
      end else begin
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            fin = 1'b1;
            case (m_kind)
              1:       {m_hi, m_lo} = {m_hi, m_lo} + m_res;
              2:       {m_hi, m_lo} = {m_hi, m_lo} - m_res;
              default: {m_hi, m_lo} = m_res;
            endcase
          end
        end
        if (!exp_in && start && (was_idle || fin) && is_mulc) begin
          if (MuDiOp == 0 || MuDiOp == 8 || MuDiOp == 10) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            m_res = 64'(sa * sb);
          end else begin
            m_res = 64'(A) * 64'(B);
          end
          m_kind = (MuDiOp >= 10) ? 2 : (MuDiOp >= 8) ? 1 : 0;
          m_left = ML;
          m_acc  = 1'b1;
        end else if (!exp_in && start && (was_idle || fin) &&
                     (MuDiOp == 2 || MuDiOp == 3) && B != 0) begin
          if (MuDiOp == 2) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
          end else begin
            sa = longint'({32'd0, A});
            sb = longint'({32'd0, B});
          end
          m_res  = {32'(sa % sb), 32'(sa / sb)};
          m_kind = 0;
          m_left = W + 1;
          m_acc  = 1'b1;
        end else if (!exp_in && was_idle && We && !start && (MuDiOp == 6 || MuDiOp == 7)) begin
          m_shi = m_hi;
          m_slo = m_lo;
          if (MuDiOp == 6) m_hi = Din;
          else             m_lo = Din;
          m_mt = 1'b1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("buzy", 32'(buzy), 32'(m_left > 0));
      chk("dout", Dout, (MuDiOp == 4) ? m_hi : (MuDiOp == 5) ? m_lo : 32'd0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    MuDiOp = op; A = a; B = b; We = 0; exp_in = 0; start = 1;
    tick();
    start = 0;
    n = 0;
    while (buzy && n < 200) begin
      tick();
      n++;
    end
    chk("op_done", 32'(buzy), 32'd0);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] d);
    MuDiOp = op; Din = d; start = 0; exp_in = 0; We = 1;
    tick();
    We = 0;
  endtask

  task automatic rd(output logic [31:0] hi, output logic [31:0] lo);
    MuDiOp = 4'd4;
    #1 hi = Dout;
    MuDiOp = 4'd5;
    #1 lo = Dout;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] hi, lo;
  int n;

  initial begin
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("rst_buzy", 32'(buzy), 32'd0);
    rd(hi, lo);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    Reset = 1'b1;
    tick();

    do_op(4'd2, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", 32'(n), 32'd33);
    rd(hi, lo);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    do_op(4'd3, 32'hFFFF_FFFF, 32'h10, n);
    rd(hi, lo);
    chk("divu_lo", lo, 32'h0FFF_FFFF);
    chk("divu_hi", hi, 32'hF);

    do_op(4'd0, 32'h8000_0000, 32'h8000_0000, n);
    chk("mult_cycles", 32'(n), 32'd5);
    rd(hi, lo);
    chk("mult_hi", hi, 32'h4000_0000);
    chk("mult_lo", lo, 32'd0);

    do_op(4'd1, 32'h8000_0000, 32'h8000_0000, n);
    rd(hi, lo);
    chk("multu_hi", hi, 32'h4000_0000);
    chk("multu_lo", lo, 32'd0);

    mt(4'd6, 32'h12);
    do_op(4'd2, 32'd5, 32'd0, n);
    chk("div0_cycles", 32'(n), 32'd0);
    rd(hi, lo);
    chk("div0_hi", hi, 32'h12);

    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    rd(hi, lo);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    mt(4'd6, 32'h55);
    mt(4'd6, 32'hAB);
    exp_in = 1;
    tick();
    exp_in = 0;
    rd(hi, lo);
    chk("mthi_rollback", hi, 32'h55);

    MuDiOp = 4'd0; A = 32'd3; B = 32'd4; start = 1;
    tick();
    start = 0; exp_in = 1;
    tick();
    exp_in = 0;
    chk("mul_abort_buzy", 32'(buzy), 32'd0);
    repeat (7) tick();
    rd(hi, lo);
    chk("mul_abort_hi", hi, 32'h55);
    chk("mul_abort_lo", lo, 32'h8000_0000);

`ifdef MUDI_MACC_EN
    mt(4'd6, 32'd0);
    mt(4'd7, 32'hFFFF_FFFF);
    do_op(4'd9, 32'd1, 32'd1, n);
    rd(hi, lo);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
    mt(4'd6, 32'd0);
    mt(4'd7, 32'd0);
    do_op(4'd10, 32'd1, 32'd1, n);
    rd(hi, lo);
    chk("msub_hi", hi, 32'hFFFF_FFFF);
    chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
    do_op(4'd10, 32'd1, 32'd1, n);
    chk("msub_ignored", 32'(n), 32'd0);
`endif

    MuDiOp = 4'd2; A = 32'd100; B = 32'd3; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    chk("mid_div_buzy", 32'(buzy), 32'd1);
    MuDiOp = 4'd4;
    #1 Reset = 0;
    #1 chk("rst_mid_buzy", 32'(buzy), 32'd0);
    chk("rst_mid_hi", Dout, 32'd0);
    #1 Reset = 1;
    tick();
    rd(hi, lo);
    chk("rst_mid_lo", lo, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      MuDiOp = 4'($urandom_range(0, 15));
      A      = pick();
      B      = pick();
      Din    = $urandom;
      start  = ($urandom_range(0, 2) == 0);
      We     = ($urandom_range(0, 3) == 0);
      exp_in = ($urandom_range(0, 9) == 0);
      tick();
    end
    start = 0; We = 0; exp_in = 0;
    n = 0;
    while (buzy && n < 100) begin
      tick();
      n++;
    end
    chk("final_idle", 32'(buzy), 32'd0);
    rd(hi, lo);
    chk("final_hi", hi, m_hi);
    chk("final_lo", lo, m_lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
